seg_scroll_display: RTL and testbench
=====================================

Name: seg_scroll_display

Overview:
Parametrised successor to the single-button 4-digit scroll display. It drives NUM_DIGITS multiplexed common-anode seven-segment digits from a writable message buffer of MSG_DEPTH characters. The window advances on a debounced button press (manual mode) or on a timer (auto mode), in either direction. It sits between the board button/switches and the anode/segment pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
MSG_DEPTH, 16, message buffer length in characters (power of 2, >= NUM_DIGITS)
REFRESH_CYCLES, 16, clocks each digit is lit per multiplex slot
DEBOUNCE_CYCLES, 64, consecutive stable clocks needed to accept a button level
SCROLL_CYCLES, 256, clocks between steps in auto mode

Ports:
clk  in  1  system clock
reset  in  1  reset; one clock; reset is synchronous and active-low
button  in  1  raw asynchronous bouncing push button
auto_mode  in  1  0 = manual step on press, 1 = timed auto-scroll
dir  in  1  0 = window moves forward (pos+1), 1 = backward (pos-1)
wr_en  in  1  write strobe for message buffer
wr_addr  in  $clog2(MSG_DEPTH)  buffer address
wr_data  in  5  character code: bit4 = blank, bits3:0 = hex glyph
an  out  NUM_DIGITS  anodes, active-low; an[NUM_DIGITS-1] is leftmost
seg  out  7  segments {a,b,c,d,e,f,g}, active-low
dp  out  1  decimal point, active-low
pos  out  $clog2(MSG_DEPTH)  current window start index

Behaviour:
- Reset (reset==0 at posedge): an all 1, seg 7'h7F, dp 1, pos 0. Buffer msg[i] = {1'b0, i[3:0]}. Debounce, refresh and scroll counters 0. Debounced level 0. Display FSM in BLANK with digit index at leftmost. Reset mid-operation aborts everything the same way; a press in progress is discarded.
- Button path: 2-FF synchroniser, then a counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive clocks of a synchronised value that differs from it. Any mismatch clears the counter. A 0->1 debounced transition emits a one-cycle step pulse. Release emits nothing.
- Step source:
  - manual: step pulse only.
  - auto: scroll counter tick every SCROLL_CYCLES clocks; the button is ignored. Entering auto (0->1 edge) clears the scroll counter.
- Step: pos <= pos+1 (dir 0) or pos-1 (dir 1), mod MSG_DEPTH. Wrap MSG_DEPTH-1 -> 0 forward and 0 -> MSG_DEPTH-1 backward. At most one step per clock.
- Window mapping: digit k counted from the left (k=0 leftmost) shows msg[(pos+k) mod MSG_DEPTH].
- Display FSM:
  - BLANK: 1 clock, an all 1, seg 7'h7F (anti-ghosting).
  - SHOW: REFRESH_CYCLES clocks, selected anode low, seg = glyph.
  - Then the next digit to the right enters BLANK; after the rightmost, the leftmost follows. Full frame = NUM_DIGITS*(REFRESH_CYCLES+1) clocks.
- Outputs are registered. Glyph and pos are sampled on entry to SHOW and held for the whole slot, so a step or write mid-slot shows from the next slot.
- Glyph: standard hex 0-F encoding. bit4=1 gives seg 7'h7F.
- Write: msg[wr_addr] <= wr_data on wr_en, one-clock write. A write and a step in the same clock both take effect. A write to the currently displayed character appears from the next SHOW entry.
- dp is 1 except as stated under Optional Feature.

Optional Feature:
Macro SEG_SCROLL_ORIGIN_MARK_EN.
- Defined: dp = 0 during SHOW on the digit whose buffer index is 0, so the wrap point is marked.
- Undefined: dp constant 1; no comparator logic is synthesised.

Decomposition:
- Package seg_scroll_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - SEG_BLANK = 7'h7F;
  - the character-code field positions;
  - the display FSM state typedef {BLANK, SHOW}.
- One sub-module: button_debouncer (synchroniser, stability counter, rise pulse), parameter DEBOUNCE_CYCLES.

Test Plan:
- Reset held 3 clocks, then released -> an=4'hF, seg=7'h7F, pos=0. First SHOW puts an=4'b0111, seg=glyph '0' (7'h01). Frame length 68 clocks.
- Manual mode, button bounces (toggles every 30 clocks for 180 clocks), then held high 200 clocks -> exactly one step, pos 0->1. Leftmost digit shows '1' next slot. Release bounce causes no step.
- Sixteen clean presses with dir=0 -> pos wraps 15->0. Then one press with dir=1 -> pos=15, digits show F,0,1,2.
- auto_mode=1 for 1024 clocks -> pos advances by exactly 4. Button presses during this time are ignored.
- wr_en with addr 2, data 5'h10 while pos=0 -> third digit blank from the next slot onward. Simultaneous write and step both take effect.
- With SEG_SCROLL_ORIGIN_MARK_EN defined and pos=14 -> dp=0 only while the third digit (index 0) is shown. Assert reset mid-SHOW -> all outputs return to reset values on the next clock.

Source files
------------

// File: rtl/seg_scroll_pkg.sv
// Shared constants for the scrolling seven-segment display: glyph table,
// character-code layout and display FSM states.
package seg_scroll_pkg;

    localparam int CH_BLANK_BIT = 4;
    localparam int CH_HEX_MSB   = 3;
    localparam int CH_HEX_LSB   = 0;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef enum logic {BLANK, SHOW} disp_state_t;

    function automatic logic [6:0] glyph_seg(input logic [4:0] ch);
        if (ch[CH_BLANK_BIT]) begin
            return SEG_BLANK;
        end
        return HEX_SEG[ch[CH_HEX_MSB:CH_HEX_LSB]];
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability counter; emits a one-cycle pulse
// when the debounced level rises.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/seg_scroll_display.sv
// Multiplexed scrolling message display with manual/auto stepping.
// Optional origin marker on dp enabled by SEG_SCROLL_ORIGIN_MARK_EN.
module seg_scroll_display
    import seg_scroll_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int MSG_DEPTH       = 16,
    parameter int REFRESH_CYCLES  = 16,
    parameter int DEBOUNCE_CYCLES = 64,
    parameter int SCROLL_CYCLES   = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         button,
    input  logic                         auto_mode,
    input  logic                         dir,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [4:0]                   wr_data,
    output logic [NUM_DIGITS-1:0]        an,
    output logic [6:0]                   seg,
    output logic                         dp,
    output logic [$clog2(MSG_DEPTH)-1:0] pos
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int RW = $clog2(REFRESH_CYCLES + 1);
    localparam int SW = $clog2(SCROLL_CYCLES + 1);
    localparam logic [NUM_DIGITS-1:0] AN_LEFT = {1'b1, {(NUM_DIGITS-1){1'b0}}};

    logic [4:0]    msg [MSG_DEPTH];
    logic          press;
    logic          scroll_tick;
    logic          step;
    logic [SW-1:0] scroll_cnt;

    disp_state_t   state;
    disp_state_t   state_nx;
    logic [DW-1:0] digit;
    logic [RW-1:0] refresh_cnt;
    logic          refresh_last;
    logic [AW-1:0] show_idx;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .button(button),
        .press (press)
    );

    // Holding the counter at zero outside auto mode is what clears it on entry.
    assign scroll_tick = auto_mode && (scroll_cnt == SW'(SCROLL_CYCLES - 1));
    assign step        = auto_mode ? scroll_tick : press;

    always_ff @(posedge clk) begin
        if (!reset || !auto_mode || scroll_tick) begin
            scroll_cnt <= '0;
        end else begin
            scroll_cnt <= scroll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos <= '0;
        end else if (step) begin
            pos <= dir ? pos - 1'b1 : pos + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < MSG_DEPTH; i++) begin
                msg[AW'(i)] <= {1'b0, 4'(i)};
            end
        end else if (wr_en) begin
            msg[wr_addr] <= wr_data;
        end
    end

    assign show_idx     = pos + AW'(digit);
    assign refresh_last = (refresh_cnt == RW'(REFRESH_CYCLES - 1));

    always_comb begin
        state_nx = state;
        case (state)
            BLANK:   state_nx = SHOW;
            SHOW:    if (refresh_last) state_nx = BLANK;
            default: state_nx = BLANK;
        endcase
    end

    // Outputs are loaded on the state transition so they line up with state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= BLANK;
            digit       <= '0;
            refresh_cnt <= '0;
            an          <= '1;
            seg         <= SEG_BLANK;
`ifdef SEG_SCROLL_ORIGIN_MARK_EN
            dp          <= 1'b1;
`endif
        end else begin
            state <= state_nx;
            if (state == BLANK) begin
                refresh_cnt <= '0;
                an          <= ~(AN_LEFT >> digit);
                seg         <= glyph_seg(msg[show_idx]);
`ifdef SEG_SCROLL_ORIGIN_MARK_EN
                dp          <= (show_idx != '0);
`endif
            end else if (refresh_last) begin
                refresh_cnt <= '0;
                an          <= '1;
                seg         <= SEG_BLANK;
                digit       <= (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
`ifdef SEG_SCROLL_ORIGIN_MARK_EN
                dp          <= 1'b1;
`endif
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

`ifndef SEG_SCROLL_ORIGIN_MARK_EN
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg_scroll_display.sv
// Directed bench for seg_scroll_display (default 4-digit, 16-char build).
module tb_seg_scroll_display;

    logic       clk = 1'b0;
    logic       reset;
    logic       button;
    logic       auto_mode;
    logic       dir;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_data;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] pos;

    always #5 clk = ~clk;

    seg_scroll_display #(
        .NUM_DIGITS     (4),
        .MSG_DEPTH      (16),
        .REFRESH_CYCLES (16),
        .DEBOUNCE_CYCLES(64),
        .SCROLL_CYCLES  (256)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .button   (button),
        .auto_mode(auto_mode),
        .dir      (dir),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .pos      (pos)
    );

    typedef struct {
        logic [4:0] data;
        logic [6:0] exp_seg;
    } glyph_vec_t;

    glyph_vec_t vecs [17];
    logic [4:0] mdl  [16];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         pos_changes = 0;
    logic [3:0] pos_prev;

    always @(posedge clk) begin
        #1;
        if (pos !== pos_prev) pos_changes++;
        pos_prev = pos;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hi, input int lo);
        button = 1'b1;
        tick(hi);
        button = 1'b0;
        tick(lo);
    endtask

    function automatic logic [6:0] mseg(input logic [4:0] c);
        if (c[4]) return 7'h7F;
        case (c[3:0])
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    function automatic logic exp_dp(input int idx);
`ifdef SEG_SCROLL_ORIGIN_MARK_EN
        return (idx % 16) != 0;
`else
        return 1'b1;
`endif
    endfunction

    // Waits for a fresh SHOW slot of digit k (0 = leftmost) and samples it.
    task automatic check_digit(input string name, input int k, input logic [6:0] exp_s, input logic exp_d);
        logic [3:0] tgt;
        int         t;
        tgt = ~(4'b1000 >> k);
        t = 0;
        while (an !== 4'hF && t < 300) begin @(negedge clk); t++; end
        while (an !== tgt && t < 300) begin @(negedge clk); t++; end
        if (an !== tgt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got an=%0h expected an=%0h", name, an, tgt);
        end else begin
            check({name, "_seg"}, 32'(seg), 32'(exp_s));
            check({name, "_dp"}, 32'(dp), 32'(exp_d));
        end
    endtask

    task automatic check_window(input string name, input int p);
        for (int k = 0; k < 4; k++) begin
            check_digit($sformatf("%s_d%0d", name, k), k, mseg(mdl[(p + k) % 16]), exp_dp((p + k) % 16));
        end
    endtask

    initial begin
        int cnt;
        int pc0;
        bit seen_off;

        vecs[0]  = '{5'h00, 7'h01};  vecs[1]  = '{5'h01, 7'h4F};  vecs[2]  = '{5'h02, 7'h12};
        vecs[3]  = '{5'h03, 7'h06};  vecs[4]  = '{5'h04, 7'h4C};  vecs[5]  = '{5'h05, 7'h24};
        vecs[6]  = '{5'h06, 7'h20};  vecs[7]  = '{5'h07, 7'h0F};  vecs[8]  = '{5'h08, 7'h00};
        vecs[9]  = '{5'h09, 7'h04};  vecs[10] = '{5'h0A, 7'h08};  vecs[11] = '{5'h0B, 7'h60};
        vecs[12] = '{5'h0C, 7'h31};  vecs[13] = '{5'h0D, 7'h42};  vecs[14] = '{5'h0E, 7'h30};
        vecs[15] = '{5'h0F, 7'h38};  vecs[16] = '{5'h15, 7'h7F};
        for (int i = 0; i < 16; i++) mdl[i] = {1'b0, 4'(i)};

        reset = 1'b0; button = 1'b0; auto_mode = 1'b0; dir = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(3);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_pos", 32'(pos), 32'h0);

        reset = 1'b1;
        tick(1);
        check("first_show_an", 32'(an), 32'h7);
        check("first_show_seg", 32'(seg), 32'h01);
        check("first_show_dp", 32'(dp), 32'(exp_dp(0)));

        cnt = 0; seen_off = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (an !== 4'h7) seen_off = 1;
        end while (!(seen_off && an === 4'h7) && cnt < 500);
        check("frame_len", 32'(cnt), 32'd68);

        // Bouncing press, then clean hold: exactly one forward step.
        pc0 = pos_changes;
        for (int i = 0; i < 6; i++) begin button = (i % 2 == 0); tick(30); end
        button = 1'b1;
        tick(200);
        check("bounce_press_pos", 32'(pos), 32'd1);
        check("bounce_press_steps", 32'(pos_changes - pc0), 32'd1);
        check_digit("bounce_left", 0, mseg(mdl[1]), exp_dp(1));

        pc0 = pos_changes;
        for (int i = 0; i < 6; i++) begin button = (i % 2 == 1); tick(30); end
        button = 1'b0;
        tick(200);
        check("release_pos", 32'(pos), 32'd1);
        check("release_steps", 32'(pos_changes - pc0), 32'd0);

        for (int p = 0; p < 15; p++) begin
            press(100, 100);
            if (p == 13) check("fwd_pos15", 32'(pos), 32'd15);
        end
        check("fwd_wrap_pos0", 32'(pos), 32'd0);

        dir = 1'b1;
        press(100, 100);
        check("bwd_wrap_pos15", 32'(pos), 32'd15);
        check_window("win15", 15);

        // Auto mode for 1024 clocks with a button press in the middle.
        dir = 1'b0;
        pc0 = pos_changes;
        auto_mode = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            button = (i >= 100 && i < 300);
            @(negedge clk);
        end
        auto_mode = 1'b0;
        button = 1'b0;
        check("auto_pos", 32'(pos), 32'd3);
        check("auto_steps", 32'(pos_changes - pc0), 32'd4);
        tick(100);
        check("auto_exit_pos", 32'(pos), 32'd3);

        dir = 1'b1;
        for (int i = 0; i < 3; i++) press(100, 100);
        check("back_to_0", 32'(pos), 32'd0);

        wr_addr = 4'd2; wr_data = 5'h10; wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
        mdl[2] = 5'h10;
        check_digit("wr_blank_d2", 2, 7'h7F, exp_dp(2));
        check_digit("wr_keep_d1", 1, mseg(mdl[1]), exp_dp(1));

        // Write lands on the same clock as the auto-scroll tick.
        dir = 1'b0;
        auto_mode = 1'b1;
        tick(255);
        wr_addr = 4'd3; wr_data = 5'h0A; wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
        auto_mode = 1'b0;
        mdl[3] = 5'h0A;
        check("wr_step_pos", 32'(pos), 32'd1);
        check_window("win1", 1);

        for (int v = 0; v < 17; v++) begin
            wr_addr = 4'd1; wr_data = vecs[v].data; wr_en = 1'b1;
            tick(1);
            wr_en = 1'b0;
            mdl[1] = vecs[v].data;
            check_digit($sformatf("glyph_%0d", v), 0, vecs[v].exp_seg, exp_dp(1));
        end

        cnt = 0;
        while (an !== 4'b1011 && cnt < 300) begin @(negedge clk); cnt++; end
        check("mid_show_found", 32'(an), 32'hB);
        tick(5);
        reset = 1'b0;
        tick(1);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_dp", 32'(dp), 32'h1);
        check("midrst_pos", 32'(pos), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = {1'b0, 4'(i)};
        check_window("win_after_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
